// File: rtl/mbox_req_seq_if.sv
// MBOX request port: held request/acknowledge handshake plus read-return and
// write-complete strobes between the EBOX cycle sequencer and the MBOX.
interface mbox_req_seq_if #(
    parameter int ADR_W  = 23,
    parameter int DATA_W = 36
);
    logic              MBOX_REQ;
    logic              MBOX_RD;
    logic              MBOX_WR;
    logic              MBOX_FETCH;
    logic [ADR_W-1:0]  MBOX_ADR;
    logic [DATA_W-1:0] MBOX_WD;
    logic              MBOX_ACK;
    logic              MBOX_RD_VALID;
    logic [DATA_W-1:0] MBOX_RD_DATA;
    logic              MBOX_WR_DONE;

    modport master (
        output MBOX_REQ, MBOX_RD, MBOX_WR, MBOX_FETCH, MBOX_ADR, MBOX_WD,
        input  MBOX_ACK, MBOX_RD_VALID, MBOX_RD_DATA, MBOX_WR_DONE
    );

    modport slave (
        input  MBOX_REQ, MBOX_RD, MBOX_WR, MBOX_FETCH, MBOX_ADR, MBOX_WD,
        output MBOX_ACK, MBOX_RD_VALID, MBOX_RD_DATA, MBOX_WR_DONE
    );
endinterface

// File: rtl/mbox_req_seq.sv
// EBOX memory-cycle sequencer: turns MCL cycle requests into held MBOX
// transactions, returns read data, holds the RPW lock and aborts on NXM timeout.
module mbox_req_seq #(
    parameter int ADR_W   = 23,
    parameter int DATA_W  = 36,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              MBOX_CYC_REQ,
    input  logic              VMA_READ,
    input  logic              VMA_WRITE,
    input  logic              VMA_PAUSE,
    input  logic              VMA_FETCH,
    input  logic [ADR_W-1:0]  VMA_ADR,
    input  logic [DATA_W-1:0] WR_DATA,
    output logic              MEM_BUSY,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              RD_LOAD,
    output logic              MBOX_LOCK,
    output logic              NXM_ERR,
    output logic              REQ_OVERRUN,
    mbox_req_seq_if.master    mbox
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_RDWAIT = 3'd2,
        ST_WRWAIT = 3'd3,
        ST_PAUSE  = 3'd4
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              req_r, rd_r, wr_r, fetch_r;
    logic [ADR_W-1:0]  adr_r;
    logic [DATA_W-1:0] wd_r;
    logic              is_rd_r, locked_rd_r, lock_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_load_r, nxm_r, ovr_r;

    logic busy_st_s, launch_s, launch_rd_s, launch_lock_s, done_s, expire_s;

    assign busy_st_s = (state_r == ST_REQ) || (state_r == ST_RDWAIT) || (state_r == ST_WRWAIT);
    assign expire_s  = busy_st_s && (cnt_r == CNT_LAST);

    // Request decode; in PAUSE any write request is the second half of RPW.
    always_comb begin
        launch_s      = 1'b0;
        launch_rd_s   = 1'b0;
        launch_lock_s = 1'b0;
        if (MBOX_CYC_REQ && ((state_r == ST_IDLE) || (state_r == ST_PAUSE))) begin
            if ((state_r == ST_PAUSE) && VMA_WRITE) begin
                launch_s      = 1'b1;
                launch_lock_s = 1'b1;
            end else if (VMA_READ) begin
                launch_s      = 1'b1;
                launch_rd_s   = 1'b1;
                launch_lock_s = VMA_PAUSE | VMA_WRITE;
            end else if (VMA_WRITE) begin
                launch_s      = 1'b1;
            end else begin
                launch_s      = 1'b0;
            end
        end else begin
            launch_s = 1'b0;
        end
    end

    // Completion strobe for the outstanding cycle; ACK may carry it directly.
    always_comb begin
        done_s = 1'b0;
        case (state_r)
            ST_REQ:    done_s = mbox.MBOX_ACK && (is_rd_r ? mbox.MBOX_RD_VALID : mbox.MBOX_WR_DONE);
            ST_RDWAIT: done_s = mbox.MBOX_RD_VALID;
            ST_WRWAIT: done_s = mbox.MBOX_WR_DONE;
            default:   done_s = 1'b0;
        endcase
    end

    // Sequencer state, request registers, lock, timeout and status pulses.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            req_r       <= 1'b0;
            rd_r        <= 1'b0;
            wr_r        <= 1'b0;
            fetch_r     <= 1'b0;
            adr_r       <= '0;
            wd_r        <= '0;
            is_rd_r     <= 1'b0;
            locked_rd_r <= 1'b0;
            lock_r      <= 1'b0;
            rd_data_r   <= '0;
            rd_load_r   <= 1'b0;
            nxm_r       <= 1'b0;
            ovr_r       <= 1'b0;
        end else begin
            rd_load_r <= 1'b0;
            nxm_r     <= 1'b0;
            ovr_r     <= MBOX_CYC_REQ & busy_st_s;
            if (launch_s) begin
                state_r     <= ST_REQ;
                cnt_r       <= '0;
                req_r       <= 1'b1;
                rd_r        <= launch_rd_s;
                wr_r        <= ~launch_rd_s;
                fetch_r     <= VMA_FETCH;
                adr_r       <= VMA_ADR;
                wd_r        <= WR_DATA;
                is_rd_r     <= launch_rd_s;
                locked_rd_r <= launch_rd_s & launch_lock_s;
                lock_r      <= launch_lock_s;
            end else if (busy_st_s && done_s) begin
                // Completion beats a coincident timeout expiry.
                req_r   <= 1'b0;
                rd_r    <= 1'b0;
                wr_r    <= 1'b0;
                fetch_r <= 1'b0;
                if (is_rd_r) begin
                    rd_data_r <= mbox.MBOX_RD_DATA;
                    rd_load_r <= 1'b1;
                    state_r   <= locked_rd_r ? ST_PAUSE : ST_IDLE;
                    lock_r    <= locked_rd_r;
                end else begin
                    state_r <= ST_IDLE;
                    lock_r  <= 1'b0;
                end
            end else if (expire_s) begin
                state_r <= ST_IDLE;
                req_r   <= 1'b0;
                rd_r    <= 1'b0;
                wr_r    <= 1'b0;
                fetch_r <= 1'b0;
                lock_r  <= 1'b0;
                nxm_r   <= 1'b1;
            end else if (busy_st_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
                if ((state_r == ST_REQ) && mbox.MBOX_ACK) begin
                    req_r   <= 1'b0;
                    rd_r    <= 1'b0;
                    wr_r    <= 1'b0;
                    fetch_r <= 1'b0;
                    state_r <= is_rd_r ? ST_RDWAIT : ST_WRWAIT;
                end
            end else if ((state_r == ST_PAUSE) && MBOX_CYC_REQ) begin
                // Typeless request in PAUSE ends the RPW pair without a new cycle.
                lock_r  <= 1'b0;
                state_r <= ST_IDLE;
            end
        end
    end

    assign MEM_BUSY        = busy_st_s | launch_s;
    assign RD_DATA         = rd_data_r;
    assign RD_LOAD         = rd_load_r;
    assign MBOX_LOCK       = lock_r;
    assign NXM_ERR         = nxm_r;
    assign REQ_OVERRUN     = ovr_r;
    assign mbox.MBOX_REQ   = req_r;
    assign mbox.MBOX_RD    = rd_r;
    assign mbox.MBOX_WR    = wr_r;
    assign mbox.MBOX_FETCH = fetch_r;
    assign mbox.MBOX_ADR   = adr_r;
    assign mbox.MBOX_WD    = wd_r;

endmodule

// File: tb/tb_mbox_req_seq.sv
// Directed, table-driven bench for mbox_req_seq with TIMEOUT=8, plus a
// hand-written asynchronous-reset-mid-transaction sequence.
module tb_mbox_req_seq;
    localparam int ADR_W   = 23;
    localparam int DATA_W  = 36;
    localparam int TIMEOUT = 8;

    localparam logic [ADR_W-1:0]  A1 = 23'o1234567, A2 = 23'o7654321, A3 = 23'o4000001;
    localparam logic [ADR_W-1:0]  A4 = 23'o0000017, A5 = 23'o0101010, A6 = 23'o0202020;
    localparam logic [ADR_W-1:0]  A7 = 23'o0303030, A8 = 23'o0404040, A0 = 23'o0000000;
    localparam logic [DATA_W-1:0] D1 = 36'o777000111222, D2 = 36'o555555000001, D3 = 36'o012345670123;
    localparam logic [DATA_W-1:0] D4 = 36'o111111111111, D5 = 36'o222222222222, D6 = 36'o333333333333;
    localparam logic [DATA_W-1:0] W1 = 36'o123456701234, W2 = 36'o000000000777, Z = 36'o0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              RESET;
    logic              cyc, vrd, vwr, vps, vfe;
    logic [ADR_W-1:0]  vadr;
    logic [DATA_W-1:0] vwd;
    logic              busy, rd_load, lock, nxm, ovr;
    logic [DATA_W-1:0] rd_data;

    mbox_req_seq_if #(.ADR_W(ADR_W), .DATA_W(DATA_W)) mb ();

    mbox_req_seq #(.ADR_W(ADR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .RESET(RESET), .MBOX_CYC_REQ(cyc), .VMA_READ(vrd), .VMA_WRITE(vwr),
        .VMA_PAUSE(vps), .VMA_FETCH(vfe), .VMA_ADR(vadr), .WR_DATA(vwd),
        .MEM_BUSY(busy), .RD_DATA(rd_data), .RD_LOAD(rd_load), .MBOX_LOCK(lock),
        .NXM_ERR(nxm), .REQ_OVERRUN(ovr), .mbox(mb.master)
    );

    // ctl = {cyc,read,write,pause,fetch,ack,rd_valid,wr_done}
    // eo  = {busy,rd_load,lock,nxm,overrun,req,mbox_rd,mbox_wr,mbox_fetch}
    typedef struct {
        int                rep;
        logic [7:0]        ctl;
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] wdat;
        logic [DATA_W-1:0] rdat;
        logic [8:0]        eo;
        logic [DATA_W-1:0] e_rd;
        logic [ADR_W-1:0]  e_adr;
        logic [DATA_W-1:0] e_wd;
    } vec_t;

    vec_t tv[$];
    int checks   = 0;
    int failures = 0;

    function automatic void add(int rep, logic [7:0] ctl, logic [ADR_W-1:0] adr, logic [DATA_W-1:0] wdat,
                                logic [DATA_W-1:0] rdat, logic [8:0] eo, logic [DATA_W-1:0] e_rd,
                                logic [ADR_W-1:0] e_adr, logic [DATA_W-1:0] e_wd);
        vec_t v;
        v = '{rep, ctl, adr, wdat, rdat, eo, e_rd, e_adr, e_wd};
        tv.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {busy, rd_load, lock, nxm, ovr, mb.MBOX_REQ, mb.MBOX_RD, mb.MBOX_WR, mb.MBOX_FETCH};
    endfunction

    task automatic drive(input logic [7:0] ctl, input logic [ADR_W-1:0] adr,
                         input logic [DATA_W-1:0] wdat, input logic [DATA_W-1:0] rdat);
        {cyc, vrd, vwr, vps, vfe, mb.MBOX_ACK, mb.MBOX_RD_VALID, mb.MBOX_WR_DONE} = ctl;
        vadr = adr;
        vwd  = wdat;
        mb.MBOX_RD_DATA = rdat;
    endtask

    initial begin
        // idle after reset
        add(1, 8'b00000000, A0, Z, Z, 9'b000000000, Z, A0, Z);
        // plain read: ACK at +2, RD_VALID at +4, RD_LOAD at +5
        add(1, 8'b11001000, A1, Z, Z, 9'b100000000, Z, A0, Z);
        add(1, 8'b00000000, A0, Z, Z, 9'b100001101, Z, A1, Z);
        add(1, 8'b00000100, A0, Z, Z, 9'b100001101, Z, A1, Z);
        add(1, 8'b00000000, A0, Z, Z, 9'b100000000, Z, A0, Z);
        add(1, 8'b00000010, A0, Z, D1, 9'b100000000, Z, A0, Z);
        add(1, 8'b00000000, A0, Z, Z, 9'b010000000, D1, A0, Z);
        add(1, 8'b00000000, A0, Z, Z, 9'b000000000, D1, A0, Z);
        // write with ACK+WR_DONE together, then a stray RD_VALID
        add(1, 8'b10100000, A2, W1, Z, 9'b100000000, D1, A0, Z);
        add(1, 8'b00000101, A0, Z, Z, 9'b100001010, D1, A2, W1);
        add(1, 8'b00000010, A0, Z, 36'o666, 9'b000000000, D1, A0, Z);
        add(1, 8'b00000000, A0, Z, Z, 9'b000000000, D1, A0, Z);
        // RPW: locked read, 10 idle cycles in PAUSE, then the write
        add(1, 8'b11010000, A3, Z, Z, 9'b100000000, D1, A0, Z);
        add(1, 8'b00000110, A0, Z, D2, 9'b101001100, D1, A3, Z);
        add(1, 8'b00000000, A0, Z, Z, 9'b011000000, D2, A0, Z);
        add(10, 8'b00000000, A0, Z, Z, 9'b001000000, D2, A0, Z);
        add(1, 8'b10100000, A3, W2, Z, 9'b101000000, D2, A0, Z);
        add(1, 8'b00000100, A0, Z, Z, 9'b101001010, D2, A3, W2);
        add(1, 8'b00000000, A0, Z, Z, 9'b101000000, D2, A0, Z);
        add(1, 8'b00000001, A0, Z, Z, 9'b101000000, D2, A0, Z);
        add(1, 8'b00000000, A0, Z, Z, 9'b000000000, D2, A0, Z);
        // overrun during RDWAIT
        add(1, 8'b11000000, A4, Z, Z, 9'b100000000, D2, A0, Z);
        add(1, 8'b00000100, A0, Z, Z, 9'b100001100, D2, A4, Z);
        add(1, 8'b11000000, A5, Z, Z, 9'b100000000, D2, A0, Z);
        add(1, 8'b00000010, A0, Z, D3, 9'b100010000, D2, A0, Z);
        add(1, 8'b00000000, A0, Z, Z, 9'b010000000, D3, A0, Z);
        add(1, 8'b00000000, A0, Z, Z, 9'b000000000, D3, A0, Z);
        // NXM timeout: no ACK for 8 cycles, late ACK ignored
        add(1, 8'b11000000, A5, Z, Z, 9'b100000000, D3, A0, Z);
        add(8, 8'b00000000, A0, Z, Z, 9'b100001100, D3, A5, Z);
        add(1, 8'b00000100, A0, Z, Z, 9'b000100000, D3, A0, Z);
        add(1, 8'b00000110, A0, Z, D4, 9'b000000000, D3, A0, Z);
        // completion on the last counted cycle beats expiry
        add(1, 8'b11000000, A6, Z, Z, 9'b100000000, D3, A0, Z);
        add(7, 8'b00000000, A0, Z, Z, 9'b100001100, D3, A6, Z);
        add(1, 8'b00000110, A0, Z, D4, 9'b100001100, D3, A6, Z);
        add(1, 8'b00000000, A0, Z, Z, 9'b010000000, D4, A0, Z);
        add(1, 8'b00000000, A0, Z, Z, 9'b000000000, D4, A0, Z);
        // PAUSE followed by a read: lock dropped, new plain read
        add(1, 8'b11010000, A7, Z, Z, 9'b100000000, D4, A0, Z);
        add(1, 8'b00000110, A0, Z, D5, 9'b101001100, D4, A7, Z);
        add(1, 8'b00000000, A0, Z, Z, 9'b011000000, D5, A0, Z);
        add(1, 8'b11000000, A8, Z, Z, 9'b101000000, D5, A0, Z);
        add(1, 8'b00000110, A0, Z, D6, 9'b100001100, D5, A8, Z);
        add(1, 8'b00000000, A0, Z, Z, 9'b010000000, D6, A0, Z);

        RESET = 1'b1;
        drive(8'b00000000, A0, Z, Z);
        #1;
        chk("in_reset outs", {55'd0, outs()}, 64'd0);
        repeat (2) @(negedge clk);
        RESET = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            for (int r = 0; r < tv[i].rep; r++) begin
                @(negedge clk);
                drive(tv[i].ctl, tv[i].adr, tv[i].wdat, tv[i].rdat);
                #1;
                chk($sformatf("row%0d.%0d outs", i, r), {55'd0, outs()}, {55'd0, tv[i].eo});
                chk($sformatf("row%0d.%0d rd_data", i, r), {28'd0, rd_data}, {28'd0, tv[i].e_rd});
                if (tv[i].eo[3]) begin
                    chk($sformatf("row%0d.%0d mbox_adr", i, r), {41'd0, mb.MBOX_ADR}, {41'd0, tv[i].e_adr});
                    chk($sformatf("row%0d.%0d mbox_wd", i, r), {28'd0, mb.MBOX_WD}, {28'd0, tv[i].e_wd});
                end
            end
        end

        // reset asserted mid-RDWAIT of a locked read
        @(negedge clk); drive(8'b11010000, A7, Z, Z);
        @(negedge clk); drive(8'b00000100, A0, Z, Z);
        @(negedge clk); drive(8'b00000000, A0, Z, Z);
        #1;
        chk("rpw_rdwait outs", {55'd0, outs()}, {55'd0, 9'b101000000});
        #2 RESET = 1'b1;
        #1;
        chk("mid_reset outs", {55'd0, outs()}, 64'd0);
        chk("mid_reset rd_data", {28'd0, rd_data}, 64'd0);
        @(negedge clk);
        RESET = 1'b0;
        drive(8'b00000010, A0, Z, D1);
        #1;
        chk("post_reset rv outs", {55'd0, outs()}, 64'd0);
        @(negedge clk);
        drive(8'b00000000, A0, Z, Z);
        #1;
        chk("post_reset outs", {55'd0, outs()}, 64'd0);
        chk("post_reset rd_data", {28'd0, rd_data}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mbox_req_seq.md
Name: mbox_req_seq

Overview:
- Sequences EBOX memory cycles requested by MCL (MBOX_CYC_REQ plus VMA_READ/WRITE/PAUSE/FETCH) into a held request/acknowledge transaction toward the MBOX.
- Returns read data for AR/ARX loading.
- Holds the MBOX lock across read-pause-write (RPW) pairs.
- Stalls the EBOX while a cycle is outstanding, and times out non-existent-memory references.
- Sits directly downstream of MCL, between MCL and the MBOX port.

Parameters:
ADR_W, 23, VMA width (bits 13:35)
DATA_W, 36, data word width
TIMEOUT, 64, max cycles from request launch to completion before NXM abort (>=4)

Ports:
clk  in  1  EBOX memory-control clock
RESET  in  1  asynchronous, active-high reset
MBOX_CYC_REQ  in  1  MCL cycle request, sampled each posedge
VMA_READ  in  1  request type: read
VMA_WRITE  in  1  request type: write
VMA_PAUSE  in  1  request type: read with pause (lock)
VMA_FETCH  in  1  instruction fetch qualifier
VMA_ADR  in  ADR_W  virtual address
WR_DATA  in  DATA_W  store data (AR)
MEM_BUSY  out  1  EBOX wait
RD_DATA  out  DATA_W  returned read word
RD_LOAD  out  1  one-cycle pulse: RD_DATA valid, load AR/ARX
MBOX_LOCK  out  1  RPW lock held
NXM_ERR  out  1  one-cycle pulse on timeout abort
REQ_OVERRUN  out  1  one-cycle pulse: CYC_REQ dropped while busy
MBOX_REQ  out  1  request valid, held until ACK
MBOX_RD  out  1  read request
MBOX_WR  out  1  write request
MBOX_FETCH  out  1  fetch qualifier
MBOX_ADR  out  ADR_W  request address
MBOX_WD  out  DATA_W  write data
MBOX_ACK  in  1  MBOX accepted request
MBOX_RD_VALID  in  1  read data valid
MBOX_RD_DATA  in  DATA_W  read data
MBOX_WR_DONE  in  1  write complete

Behaviour:
- Reset (async):
  - State=IDLE.
  - All outputs 0, RD_DATA=0.
  - Timeout counter=0.
  - Reset mid-transaction abandons the cycle silently: no NXM, no RD_LOAD, lock released.
- Request decode (at posedge with CYC_REQ=1 in IDLE or PAUSE):
  - READ&(PAUSE|WRITE) -> locked read (RPW).
  - READ alone -> plain read.
  - WRITE alone -> write.
  - No type bit set -> no-op: ignored, no pulse.
- Launch: on an accepted request, latch ADR, FETCH, WR_DATA and type into request registers. Go to REQ; MBOX_REQ=1 from the next cycle.
- REQ: MBOX_REQ/RD/WR/ADR/WD stay stable until MBOX_ACK is sampled 1.
  - After ACK, a read goes to RDWAIT and a write goes to WRWAIT.
  - If RD_VALID (read) or WR_DONE (write) arrives in the same cycle as ACK, complete directly.
- RDWAIT: on MBOX_RD_VALID, register RD_DATA and pulse RD_LOAD the next cycle.
  - Locked read -> PAUSE with MBOX_LOCK=1.
  - Plain read -> IDLE.
- WRWAIT: on MBOX_WR_DONE -> IDLE; clear MBOX_LOCK in the same edge.
- PAUSE: MEM_BUSY=0, lock held.
  - CYC_REQ with WRITE set -> write launch, lock kept until WR_DONE.
  - CYC_REQ without WRITE -> lock dropped, request decoded as new.
  - Otherwise wait indefinitely; no timeout in PAUSE.
- MEM_BUSY:
  - Combinational: 1 when state is REQ, RDWAIT or WRWAIT, or when an accepted non-no-op CYC_REQ is present this cycle.
  - Goes 0 in the same cycle RD_LOAD is 1, or the cycle after WR_DONE.
- Overrun: CYC_REQ in REQ/RDWAIT/WRWAIT is dropped and REQ_OVERRUN pulses the next cycle. The state is unaffected.
- Timeout:
  - Counter clears on launch and increments each cycle in REQ/RDWAIT/WRWAIT.
  - At count TIMEOUT-1 without completion: go to IDLE, pulse NXM_ERR next cycle, drop MBOX_REQ and MBOX_LOCK. RD_LOAD does not pulse.
  - Completion and expiry in the same cycle: completion wins.
- Stray inputs: RD_VALID, WR_DONE and ACK are ignored outside their waiting states.
- Latency: best case, a read with ACK and RD_VALID arriving the cycle after launch gives RD_LOAD 2 cycles after CYC_REQ.

Test Plan:
- Plain read: CYC_REQ+READ, ADR=0o1234567; ACK at +2, RD_VALID with data 0o777000111222 at +4 -> MBOX_REQ held at +1..+2, RD_LOAD=1 at +5 with RD_DATA=0o777000111222, MEM_BUSY=0 at +5, state IDLE.
- Write with ACK+WR_DONE in the same cycle: WR_DATA=0o123456701234 -> MBOX_WD matches; MEM_BUSY falls the next cycle; no RD_LOAD.
- RPW: READ+PAUSE, data returned -> MBOX_LOCK=1 and MEM_BUSY=0 in PAUSE; idle 10 cycles, lock stays; CYC_REQ+WRITE -> MBOX_WR=1, lock=1 until WR_DONE, then 0.
- Timeout with TIMEOUT=8: read, ACK never asserted -> NXM_ERR single pulse 8 cycles after launch, MBOX_REQ=0, MEM_BUSY=0; a late ACK is ignored.
- Overrun: second CYC_REQ during RDWAIT -> REQ_OVERRUN pulse; the first read completes normally; no second MBOX_REQ.
- Reset asserted mid-RDWAIT with lock held -> all outputs 0 immediately; RD_VALID after reset release is ignored.
